// File: rtl/ctx_stack_pkg.sv
// Shared types and elaboration helpers for the multi-context traversal stack.
package ctx_stack_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 128;
    localparam int DEF_NUM_CTX    = 4;
    localparam int DEF_PTR_W      = $clog2(DEF_DEPTH);
    localparam int DEF_CNT_W      = $clog2(DEF_DEPTH + 1);
    localparam int DEF_CTX_W      = (DEF_NUM_CTX > 1) ? $clog2(DEF_NUM_CTX) : 1;

    typedef logic [DEF_CTX_W-1:0]      ctx_t;
    typedef logic [DEF_PTR_W-1:0]      ptr_t;
    typedef logic [DEF_CNT_W-1:0]      cnt_t;
    typedef logic [DEF_DATA_WIDTH-1:0] data_t;

    function automatic int ctx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    function automatic logic [DEF_CTX_W+DEF_PTR_W-1:0] addr(input ctx_t c, input ptr_t p);
        return {c, p};
    endfunction

endpackage

// File: rtl/ctx_stack_if.sv
// Request/response bundle between traversal FSMs (master) and ctx_stack (slave).
interface ctx_stack_if
    import ctx_stack_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int NUM_CTX    = DEF_NUM_CTX
) ();
    localparam int CTX_W = ctx_width(NUM_CTX);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                     push_valid;
    logic                     push_ready;
    logic [CTX_W-1:0]         push_ctx;
    logic [DATA_WIDTH-1:0]    push_data;
    logic                     pop_valid;
    logic                     pop_ready;
    logic [CTX_W-1:0]         pop_ctx;
    logic                     pop_resp_valid;
    logic [CTX_W-1:0]         pop_resp_ctx;
    logic [DATA_WIDTH-1:0]    pop_resp_data;
    logic                     flush_valid;
    logic [CTX_W-1:0]         flush_ctx;
    logic [NUM_CTX*CNT_W-1:0] count;
    logic [NUM_CTX-1:0]       full;
    logic [NUM_CTX-1:0]       empty;

    modport master (
        output push_valid, push_ctx, push_data, pop_valid, pop_ctx, flush_valid, flush_ctx,
        input  push_ready, pop_ready, pop_resp_valid, pop_resp_ctx, pop_resp_data,
               count, full, empty
    );

    modport slave (
        input  push_valid, push_ctx, push_data, pop_valid, pop_ctx, flush_valid, flush_ctx,
        output push_ready, pop_ready, pop_resp_valid, pop_resp_ctx, pop_resp_data,
               count, full, empty
    );
endinterface

// File: rtl/ctx_stack_ram.sv
// Simple dual-port RAM, one write port and one registered read-first read port.
module ctx_stack_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Non-blocking read of the pre-write contents gives read-first on collision;
    // the output register reset maps onto the BRAM output-latch reset.
    always_ff @(posedge clk) begin
        if (reset)   rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/ctx_stack.sv
// Multi-context LIFO: NUM_CTX stacks partitioned in one RAM, with replace-top and per-context flush.
module ctx_stack
    import ctx_stack_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int NUM_CTX    = DEF_NUM_CTX
) (
    input  logic       clk,
    input  logic       reset,
    ctx_stack_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int CTX_W = ctx_width(NUM_CTX);
    localparam int AW    = CTX_W + PTR_W;

    if (!is_pow2(DEPTH)) begin : g_depth_chk
        $error("ctx_stack: DEPTH must be a power of two");
    end
    if (NUM_CTX < 1) begin : g_ctx_chk
        $error("ctx_stack: NUM_CTX must be at least 1");
    end

    logic [NUM_CTX-1:0][CNT_W-1:0] cnt, cnt_nxt;
    logic [PTR_W-1:0] pop_ptr, push_ptr;
    logic             pop_fire, push_fire, replace;
    logic             resp_valid;
    logic [CTX_W-1:0] resp_ctx;

    for (genvar i = 0; i < NUM_CTX; i++) begin : g_flags
        assign bus.full[i]  = (cnt[i] == CNT_W'(DEPTH));
        assign bus.empty[i] = (cnt[i] == '0);
    end
    assign bus.count = cnt;

    assign bus.pop_ready  = !bus.empty[bus.pop_ctx] &&
                            !(bus.flush_valid && bus.flush_ctx == bus.pop_ctx);
    assign pop_fire       = bus.pop_valid && bus.pop_ready;
    // A full context can still take a push when the same-cycle pop frees its top slot.
    assign bus.push_ready = !(bus.flush_valid && bus.flush_ctx == bus.push_ctx) &&
                            (!bus.full[bus.push_ctx] || (pop_fire && bus.pop_ctx == bus.push_ctx));
    assign push_fire      = bus.push_valid && bus.push_ready;
    assign replace        = push_fire && pop_fire && (bus.push_ctx == bus.pop_ctx);

    assign pop_ptr  = PTR_W'(cnt[bus.pop_ctx] - CNT_W'(1));
    assign push_ptr = replace ? pop_ptr : PTR_W'(cnt[bus.push_ctx]);

    always_comb begin
        cnt_nxt = cnt;
        for (int i = 0; i < NUM_CTX; i++) begin
            if (bus.flush_valid && bus.flush_ctx == CTX_W'(i)) begin
                cnt_nxt[i] = '0;
            end else begin
                if (push_fire && !replace && bus.push_ctx == CTX_W'(i))
                    cnt_nxt[i] = cnt_nxt[i] + CNT_W'(1);
                if (pop_fire && !replace && bus.pop_ctx == CTX_W'(i))
                    cnt_nxt[i] = cnt_nxt[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_ctx   <= '0;
        end else begin
            cnt        <= cnt_nxt;
            resp_valid <= pop_fire;
            if (pop_fire) resp_ctx <= bus.pop_ctx;
        end
    end

    assign bus.pop_resp_valid = resp_valid;
    assign bus.pop_resp_ctx   = resp_ctx;

    ctx_stack_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (AW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (push_fire),
        .waddr ({bus.push_ctx, push_ptr}),
        .wdata (bus.push_data),
        .re    (pop_fire),
        .raddr ({bus.pop_ctx, pop_ptr}),
        .rdata (bus.pop_resp_data)
    );
endmodule

// File: tb/tb_ctx_stack.sv
// Self-checking bench for ctx_stack: directed table, corner sequences, and random traffic vs a queue model.
module tb_ctx_stack;
    import ctx_stack_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int NC    = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ctx_stack_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CTX(NC)) bus ();
    ctx_stack #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CTX(NC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: one queue per context, back of queue is the stack top.
    int unsigned q [NC][$];
    bit          m_rv;
    int unsigned m_rctx, m_rdata;

    typedef struct {
        bit pv; int pc; int pd;
        bit ov; int oc;
        bit fv; int fc;
        bit e_prdy; bit e_ordy; bit e_rv; int e_rdata;
    } vec_t;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [NC-1:0] ef, ee;
        chk("resp_valid", bus.pop_resp_valid, m_rv);
        chk("resp_data", bus.pop_resp_data, m_rdata);
        if (m_rv) chk("resp_ctx", bus.pop_resp_ctx, m_rctx);
        for (int i = 0; i < NC; i++) begin
            chk($sformatf("count%0d", i), bus.count[i*CNT_W +: CNT_W], q[i].size());
            ef[i] = (q[i].size() == DEPTH);
            ee[i] = (q[i].size() == 0);
        end
        chk("full", bus.full, ef);
        chk("empty", bus.empty, ee);
    endtask

    task automatic idle();
        bus.push_valid = 0; bus.push_ctx = '0; bus.push_data = '0;
        bus.pop_valid = 0; bus.pop_ctx = '0;
        bus.flush_valid = 0; bus.flush_ctx = '0;
    endtask

    // Called at posedge+1: drive, check readies, clock, check results.
    task automatic step(input bit pv, input int pc, input int pd, input bit ov, input int oc,
                        input bit fv, input int fc, output bit prdy, output bit ordy);
        bit mp, mo, pf, of;
        bus.push_valid = pv; bus.push_ctx = pc[1:0]; bus.push_data = pd[DW-1:0];
        bus.pop_valid = ov; bus.pop_ctx = oc[1:0];
        bus.flush_valid = fv; bus.flush_ctx = fc[1:0];
        #1;
        mo = (q[oc].size() > 0) && !(fv && fc == oc);
        mp = !(fv && fc == pc) && ((q[pc].size() < DEPTH) || (ov && mo && oc == pc));
        chk("push_ready", bus.push_ready, mp);
        chk("pop_ready", bus.pop_ready, mo);
        prdy = bus.push_ready;
        ordy = bus.pop_ready;
        pf = pv && mp;
        of = ov && mo;
        m_rv = of;
        if (of) begin
            m_rctx  = oc;
            m_rdata = q[oc].pop_back();
        end
        if (pf) q[pc].push_back(pd & 8'hFF);
        if (fv) q[fc].delete();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input bit pop_active);
        reset = 1'b1;
        bus.pop_valid = pop_active;
        @(posedge clk);
        #1;
        for (int i = 0; i < NC; i++) q[i].delete();
        m_rv = 0; m_rctx = 0; m_rdata = 0;
        reset = 1'b0;
        idle();
        check_outputs();
    endtask

    vec_t vt[$];
    bit   pr, orr;

    initial begin
        idle();
        @(posedge clk);
        #1;
        do_reset(1'b0);

        // Directed table: LIFO order, cross-context push+pop, empty pop, flush, replace-top.
        vt = '{
            '{1,0,5, 0,0, 0,0, 1,0,0,0},
            '{1,0,6, 0,0, 0,0, 1,1,0,0},
            '{1,0,7, 0,0, 0,0, 1,1,0,0},
            '{0,0,0, 1,0, 0,0, 1,1,1,7},
            '{0,0,0, 1,0, 0,0, 1,1,1,6},
            '{0,0,0, 1,0, 0,0, 1,1,1,5},
            '{1,3,4, 0,0, 0,0, 1,0,0,5},
            '{1,0,8, 1,3, 0,0, 1,1,1,4},
            '{0,2,0, 1,2, 0,0, 1,0,0,4},
            '{1,0,3, 0,2, 1,0, 0,0,0,4},
            '{1,0,1, 0,0, 0,0, 1,0,0,4},
            '{1,0,2, 0,0, 0,0, 1,1,0,4},
            '{1,0,9, 1,0, 0,0, 1,1,1,2},
            '{0,0,0, 1,0, 0,0, 1,1,1,9},
            '{0,0,0, 1,0, 0,0, 1,1,1,1}
        };
        foreach (vt[k]) begin
            step(vt[k].pv, vt[k].pc, vt[k].pd, vt[k].ov, vt[k].oc, vt[k].fv, vt[k].fc, pr, orr);
            chk($sformatf("tbl%0d_push_ready", k), pr, vt[k].e_prdy);
            chk($sformatf("tbl%0d_pop_ready", k), orr, vt[k].e_ordy);
            chk($sformatf("tbl%0d_resp_valid", k), bus.pop_resp_valid, vt[k].e_rv);
            chk($sformatf("tbl%0d_resp_data", k), bus.pop_resp_data, vt[k].e_rdata);
        end
        chk("tbl_count0_end", bus.count[0 +: CNT_W], 0);

        // Fill ctx1, then check backpressure, neighbour push and replace-top while full.
        idle();
        do_reset(1'b0);
        for (int k = 0; k < DEPTH; k++) step(1, 1, 100 + k, 0, 0, 0, 0, pr, orr);
        chk("fill_full1", bus.full[1], 1);
        step(1, 1, 8'hAA, 0, 0, 0, 0, pr, orr);
        chk("full_push_refused", pr, 0);
        step(1, 2, 8'h33, 0, 0, 0, 0, pr, orr);
        chk("ctx2_push_ok", pr, 1);
        step(1, 1, 8'h5A, 1, 1, 0, 0, pr, orr);
        chk("replace_full_accept", pr, 1);
        chk("replace_full_resp", bus.pop_resp_data, 100 + DEPTH - 1);
        chk("replace_full_count", bus.count[CNT_W +: CNT_W], DEPTH);
        step(0, 0, 0, 1, 1, 0, 0, pr, orr);
        chk("pop_after_replace", bus.pop_resp_data, 8'h5A);

        // Reset in the cycle after an accepted pop kills the next response.
        idle();
        do_reset(1'b0);
        step(1, 0, 8'h11, 0, 0, 0, 0, pr, orr);
        step(1, 0, 8'h22, 0, 0, 0, 0, pr, orr);
        step(0, 0, 0, 1, 0, 0, 0, pr, orr);
        chk("pre_reset_resp", bus.pop_resp_valid, 1);
        do_reset(1'b1);
        chk("post_reset_resp_valid", bus.pop_resp_valid, 0);
        chk("post_reset_count0", bus.count[0 +: CNT_W], 0);

        // Random traffic: push-heavy first half to reach full, pop-heavy second half.
        for (int n = 0; n < 1600; n++) begin
            int pp, po;
            pp = (n < 800) ? 75 : 35;
            po = (n < 800) ? 30 : 70;
            if ($urandom_range(0, 299) == 0) begin
                do_reset($urandom_range(0, 1) == 1);
            end else begin
                step($urandom_range(0, 99) < pp, $urandom_range(0, NC - 1), $urandom_range(0, 255),
                     $urandom_range(0, 99) < po, $urandom_range(0, NC - 1),
                     $urandom_range(0, 99) < 3, $urandom_range(0, NC - 1), pr, orr);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
